q4_stim_checker: RTL and testbench

Self-checking stimulus driver and response checker for the two-input `z = f(x, y)` combinational logic block. It produces the `x`/`y` inputs and consumes `z`, which is the opposite end of that block's interface. On `start`, it sweeps all four input vectors for a set number of passes and waits a programmable settle time before sampling `z`. It compares each sample against the golden function `z = x | ~y`, then reports the error count, the first failing vector and a pass/fail result. It sits beside the logic block in the built-in self-test wrapper.

---
 rtl/q4_stim_checker.sv | 184 ++++++++++++++++++
 tb/tb_q4_stim_checker.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/q4_stim_checker.sv
// ----------------------------------------------------------------------------
// q4_stim_checker
//   Built-in self-test driver/checker for a two-input combinational block
//   z = f(x, y). On start it sweeps {x,y} = 00,01,10,11 for NUM_PASSES passes,
//   holds each vector SETTLE_CYCLES extra cycles, samples z on the last cycle
//   of the window and compares it against the golden function z = x | ~y.
//   Results (error count, first failing vector, pass flag) are held in IDLE
//   until the next accepted start.
//
// Parameters
//   NUM_PASSES     full 4-vector sweeps per run (1..255)
//   SETTLE_CYCLES  extra hold cycles before z is sampled (0..15)
//
// Ports
//   clk              rising-edge clock
//   resetn           asynchronous active-low reset
//   start            run request, only looked at in IDLE
//   x, y             registered stimulus to the block under test
//   z                response from the block under test
//   busy             high in DRIVE / SAMPLE / DONE
//   done             one-cycle pulse at the end of a run
//   pass             last completed run had zero mismatches (held)
//   err_count        mismatch count, saturating at 255
//   first_err_valid  a mismatch has been captured this run
//   first_err_vec    {x,y} of the first mismatch this run
// ----------------------------------------------------------------------------
module q4_stim_checker #(
    parameter int NUM_PASSES    = 4,
    parameter int SETTLE_CYCLES = 1
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       start,
    output logic       x,
    output logic       y,
    input  logic       z,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [7:0] err_count,
    output logic       first_err_valid,
    output logic [1:0] first_err_vec
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DRIVE,
        ST_SAMPLE,
        ST_DONE
    } state_t;

    // Last pass index and last settle count; with no settle time the DRIVE
    // state is skipped entirely, so the settle compare value is unused.
    localparam logic [7:0] PASS_LAST   = 8'(NUM_PASSES - 1);
    localparam logic [3:0] SETTLE_LAST = (SETTLE_CYCLES > 0) ? 4'(SETTLE_CYCLES - 1) : 4'd0;
    localparam state_t     ST_VEC      = (SETTLE_CYCLES > 0) ? ST_DRIVE : ST_SAMPLE;

    state_t     r_state,    w_state_nxt;
    logic [1:0] r_vec,      w_vec_nxt;
    logic [7:0] r_pass_cnt, w_pass_cnt_nxt;
    logic [3:0] r_settle,   w_settle_nxt;
    logic [7:0] r_err,      w_err_nxt;
    logic       r_fvalid,   w_fvalid_nxt;
    logic [1:0] r_fvec,     w_fvec_nxt;
    logic       r_pass,     w_pass_nxt;
    logic       r_x, r_y, r_busy, r_done;

    logic       w_expect;
    logic       w_mismatch;
    logic       w_drive_vec;

    // Golden response for the vector currently presented.
    assign w_expect   = r_vec[1] | ~r_vec[0];
    assign w_mismatch = (r_state == ST_SAMPLE) && (z != w_expect);

    // ------------------------------------------------------------------------
    // Next-state / datapath
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt    = r_state;
        w_vec_nxt      = r_vec;
        w_pass_cnt_nxt = r_pass_cnt;
        w_settle_nxt   = r_settle;
        w_err_nxt      = r_err;
        w_fvalid_nxt   = r_fvalid;
        w_fvec_nxt     = r_fvec;
        w_pass_nxt     = r_pass;

        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_err_nxt      = 8'd0;
                    w_fvalid_nxt   = 1'b0;
                    w_fvec_nxt     = 2'b00;
                    w_pass_nxt     = 1'b0;
                    w_vec_nxt      = 2'b00;
                    w_pass_cnt_nxt = 8'd0;
                    w_settle_nxt   = 4'd0;
                    w_state_nxt    = ST_VEC;
                end
            end

            ST_DRIVE: begin
                w_settle_nxt = r_settle + 4'd1;
                if (r_settle == SETTLE_LAST)
                    w_state_nxt = ST_SAMPLE;
            end

            ST_SAMPLE: begin
                if (w_mismatch) begin
                    if (r_err != 8'hFF)
                        w_err_nxt = r_err + 8'd1;
                    if (!r_fvalid) begin
                        w_fvalid_nxt = 1'b1;
                        w_fvec_nxt   = r_vec;
                    end
                end
                if (r_vec == 2'b11 && r_pass_cnt == PASS_LAST) begin
                    w_state_nxt = ST_DONE;
                end else begin
                    w_vec_nxt    = r_vec + 2'd1;
                    w_settle_nxt = 4'd0;
                    w_state_nxt  = ST_VEC;
                    if (r_vec == 2'b11)
                        w_pass_cnt_nxt = r_pass_cnt + 8'd1;
                end
            end

            ST_DONE: begin
                // r_err already includes the final SAMPLE's mismatch here.
                w_pass_nxt  = (r_err == 8'd0);
                w_state_nxt = ST_IDLE;
            end

            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Stimulus is only driven while a vector window is active.
    assign w_drive_vec = (w_state_nxt == ST_DRIVE) || (w_state_nxt == ST_SAMPLE);

    // ------------------------------------------------------------------------
    // State and output registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state    <= ST_IDLE;
            r_vec      <= 2'b00;
            r_pass_cnt <= 8'd0;
            r_settle   <= 4'd0;
            r_err      <= 8'd0;
            r_fvalid   <= 1'b0;
            r_fvec     <= 2'b00;
            r_pass     <= 1'b0;
            r_x        <= 1'b0;
            r_y        <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_vec      <= w_vec_nxt;
            r_pass_cnt <= w_pass_cnt_nxt;
            r_settle   <= w_settle_nxt;
            r_err      <= w_err_nxt;
            r_fvalid   <= w_fvalid_nxt;
            r_fvec     <= w_fvec_nxt;
            r_pass     <= w_pass_nxt;
            r_x        <= w_drive_vec ? w_vec_nxt[1] : 1'b0;
            r_y        <= w_drive_vec ? w_vec_nxt[0] : 1'b0;
            r_busy     <= (w_state_nxt != ST_IDLE);
            r_done     <= (w_state_nxt == ST_DONE);
        end
    end

    assign x               = r_x;
    assign y               = r_y;
    assign busy            = r_busy;
    assign done            = r_done;
    assign pass            = r_pass;
    assign err_count       = r_err;
    assign first_err_valid = r_fvalid;
    assign first_err_vec   = r_fvec;

endmodule

// File: tb/tb_q4_stim_checker.sv
// ----------------------------------------------------------------------------
// tb_q4_stim_checker
//   Four checker instances with different parameter sets, each closing the
//   loop through a programmable 4-entry truth table standing in for the block
//   under test (tt[{x,y}] = z). Directed table runs, hand-written corner
//   sequences (start held, mid-run reset, saturation) and random truth tables
//   compared against an arithmetic reference model.
// ----------------------------------------------------------------------------
module tb_q4_stim_checker;

    localparam logic [3:0] GOLD = 4'b1101; // bit v = expected z for {x,y}=v

    logic       clk = 1'b0;
    logic       resetn;
    logic [3:0] start, x, y, z, busy, done, pass, fval;
    logic [7:0] errc [4];
    logic [1:0] fev  [4];
    logic [3:0] tt_r [4];

    int errs   = 0;
    int checks = 0;

    always #5 clk = ~clk;

    always_comb begin
        for (int i = 0; i < 4; i++) z[i] = tt_r[i][{x[i], y[i]}];
    end

    q4_stim_checker u0 (
        .clk(clk), .resetn(resetn), .start(start[0]), .x(x[0]), .y(y[0]), .z(z[0]),
        .busy(busy[0]), .done(done[0]), .pass(pass[0]), .err_count(errc[0]),
        .first_err_valid(fval[0]), .first_err_vec(fev[0]));

    q4_stim_checker #(.NUM_PASSES(1), .SETTLE_CYCLES(0)) u1 (
        .clk(clk), .resetn(resetn), .start(start[1]), .x(x[1]), .y(y[1]), .z(z[1]),
        .busy(busy[1]), .done(done[1]), .pass(pass[1]), .err_count(errc[1]),
        .first_err_valid(fval[1]), .first_err_vec(fev[1]));

    q4_stim_checker #(.NUM_PASSES(100), .SETTLE_CYCLES(1)) u2 (
        .clk(clk), .resetn(resetn), .start(start[2]), .x(x[2]), .y(y[2]), .z(z[2]),
        .busy(busy[2]), .done(done[2]), .pass(pass[2]), .err_count(errc[2]),
        .first_err_valid(fval[2]), .first_err_vec(fev[2]));

    q4_stim_checker #(.NUM_PASSES(3), .SETTLE_CYCLES(2)) u3 (
        .clk(clk), .resetn(resetn), .start(start[3]), .x(x[3]), .y(y[3]), .z(z[3]),
        .busy(busy[3]), .done(done[3]), .pass(pass[3]), .err_count(errc[3]),
        .first_err_valid(fval[3]), .first_err_vec(fev[3]));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference: every pass hits each vector once, so the error total is
    // passes x (number of truth-table entries differing from the golden
    // function), capped at 255; the first error is the lowest differing vector.
    function automatic void model(input logic [3:0] tt, input int np,
                                  output logic [7:0] e_err, output logic [1:0] e_fv,
                                  output logic e_fval, output logic e_pass);
        int n, tot;
        n = 0; e_fv = 2'b00; e_fval = 1'b0;
        for (int v = 0; v < 4; v++) begin
            bit g;
            g = ((v / 2) % 2 == 1) || (v % 2 == 0);
            if (tt[v] != g) begin
                if (n == 0) begin e_fv = 2'(v); e_fval = 1'b1; end
                n++;
            end
        end
        tot    = n * np;
        e_err  = (tot > 255) ? 8'hFF : 8'(tot);
        e_pass = (n == 0);
    endfunction

    // One complete run on instance d: accept, per-cycle busy/done/stimulus
    // checks over the whole window, then held results in IDLE.
    task automatic run_one(input int d, input logic [3:0] tt, input int np, input int st,
                           input logic [7:0] e_err, input logic [1:0] e_fv,
                           input logic e_fval, input logic e_pass,
                           input bit seq, input bit noise, input string tag);
        int L;
        int bad_busy, bad_done, bad_seq;
        logic [1:0] exy;
        L = 4 * np * (st + 1);
        bad_busy = 0; bad_done = 0; bad_seq = 0;
        @(posedge clk); #1;
        tt_r[d]  = tt;
        start[d] = 1'b1;
        @(posedge clk); #1;              // accept edge
        start[d] = noise ? 1'($urandom_range(0, 1)) : 1'b0;
        for (int k = 1; k <= L + 1; k++) begin
            @(negedge clk);
            if (busy[d] !== 1'b1) bad_busy++;
            if (done[d] !== (k == L + 1)) bad_done++;
            if (seq) begin
                exy = (k <= L) ? 2'(((k - 1) / (st + 1)) % 4) : 2'b00;
                if ({x[d], y[d]} !== exy) bad_seq++;
            end
            @(posedge clk); #1;
            start[d] = (noise && k < L + 1) ? 1'($urandom_range(0, 1)) : 1'b0;
        end
        @(negedge clk);
        chk({tag, " busy window"}, 32'(bad_busy), 0);
        chk({tag, " done pulse"},  32'(bad_done), 0);
        if (seq) chk({tag, " xy sequence"}, 32'(bad_seq), 0);
        chk({tag, " idle busy/done"}, {30'd0, busy[d], done[d]}, 0);
        chk({tag, " err_count"},       32'(errc[d]), 32'(e_err));
        chk({tag, " first_err_valid"}, 32'(fval[d]), 32'(e_fval));
        if (e_fval) chk({tag, " first_err_vec"}, 32'(fev[d]), 32'(e_fv));
        chk({tag, " pass"},            32'(pass[d]), 32'(e_pass));
    endtask

    typedef struct {
        logic [3:0] tt;
        logic [7:0] e_err;
        logic [1:0] e_fv;
        logic       e_fval;
        logic       e_pass;
    } rec_t;

    rec_t tbl [5];

    initial begin
        logic [7:0] m_err;
        logic [1:0] m_fv;
        logic       m_fval, m_pass;
        logic [3:0] rtt;
        int         bad;

        // Defaults (4 passes, settle 1): {tt, err, first_vec, first_valid, pass}
        tbl[0] = '{GOLD,    8'd0,  2'b00, 1'b0, 1'b1}; // correct block
        tbl[1] = '{4'b0000, 8'd12, 2'b00, 1'b1, 1'b0}; // z stuck at 0
        tbl[2] = '{4'b1111, 8'd4,  2'b01, 1'b1, 1'b0}; // z stuck at 1
        tbl[3] = '{4'b1001, 8'd4,  2'b10, 1'b1, 1'b0}; // wrong only at 10
        tbl[4] = '{4'b0101, 8'd4,  2'b11, 1'b1, 1'b0}; // wrong only at final vector

        resetn = 1'b0;
        start  = 4'b0;
        for (int i = 0; i < 4; i++) tt_r[i] = GOLD;
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < 4; i++)
            chk($sformatf("reset values u%0d", i),
                32'({x[i], y[i], busy[i], done[i], pass[i], errc[i], fval[i], fev[i]}), 0);
        resetn = 1'b1;

        for (int t = 0; t < 5; t++)
            run_one(0, tbl[t].tt, 4, 1, tbl[t].e_err, tbl[t].e_fv, tbl[t].e_fval,
                    tbl[t].e_pass, 1'b1, 1'b0, $sformatf("tbl%0d", t));

        // Inverted model, 1 pass, no settle: done on the 5th cycle after accept
        run_one(1, ~GOLD, 1, 0, 8'd4, 2'b00, 1'b1, 1'b0, 1'b1, 1'b0, "inverted");

        // 300 mismatches must saturate at 255
        run_one(2, 4'b0000, 100, 1, 8'hFF, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, "saturate");

        // start held high throughout: one run, then a re-accept from IDLE
        @(posedge clk); #1;
        tt_r[0]  = 4'b0000;
        start[0] = 1'b1;
        @(posedge clk); #1;              // accept edge
        bad = 0;
        for (int k = 1; k <= 33; k++) begin
            @(negedge clk);
            if (busy[0] !== 1'b1 || done[0] !== (k == 33)) bad++;
        end
        chk("held start single run", 32'(bad), 0);
        @(negedge clk);                  // IDLE cycle, start still high
        chk("held start idle busy", 32'(busy[0]), 0);
        chk("held start idle err",  32'(errc[0]), 32'd12);
        @(negedge clk);                  // first cycle of the second run
        chk("held start rerun busy", 32'(busy[0]), 1);
        chk("held start cleared",    32'({errc[0], fval[0], pass[0], x[0], y[0]}), 0);

        // Mid-run reset with start asserted throughout reset
        repeat (4) @(negedge clk);
        resetn = 1'b0;
        #1;
        chk("mid-run reset values",
            32'({x[0], y[0], busy[0], done[0], pass[0], errc[0], fval[0], fev[0]}), 0);
        bad = 0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (busy[0] !== 1'b0 || done[0] !== 1'b0 || errc[0] !== 8'd0) bad++;
        end
        chk("start ignored in reset", 32'(bad), 0);
        start[0] = 1'b0;
        resetn   = 1'b1;
        bad = 0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (busy[0] !== 1'b0 || done[0] !== 1'b0 || {x[0], y[0]} !== 2'b00) bad++;
        end
        chk("no activity after reset", 32'(bad), 0);

        run_one(0, GOLD, 4, 1, 8'd0, 2'b00, 1'b0, 1'b1, 1'b1, 1'b0, "recover");

        // Random truth tables with start noise during the run
        for (int r = 0; r < 8; r++) begin
            rtt = 4'($urandom);
            model(rtt, 3, m_err, m_fv, m_fval, m_pass);
            run_one(3, rtt, 3, 2, m_err, m_fv, m_fval, m_pass, 1'b1, 1'b1,
                    $sformatf("rnd3_%0d tt=%b", r, rtt));
            repeat ($urandom_range(0, 3)) @(posedge clk);
        end
        for (int r = 0; r < 4; r++) begin
            rtt = 4'($urandom);
            model(rtt, 4, m_err, m_fv, m_fval, m_pass);
            run_one(0, rtt, 4, 1, m_err, m_fv, m_fval, m_pass, 1'b1, 1'b1,
                    $sformatf("rnd0_%0d tt=%b", r, rtt));
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
